// File: rtl/pipeline_ctrl_pkg.sv
// rv32i_types: shared types and widths for the pipeline controller
package rv32i_types;
    typedef enum logic {RUN, MEM_WAIT} pipe_ctrl_state_t;
    localparam int REG_W    = 5;
    localparam int FREEZE_W = 32;
    localparam int BUBBLE_W = 16;
endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: load-use comparison between the ID/EX load and the IF/ID sources
module hazard_detect
    import rv32i_types::*;
(
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_rd,
    input  logic [REG_W-1:0] ifid_rs1,
    input  logic [REG_W-1:0] ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    output logic             hazard
);
    // x0 is never a real producer, so a load into it cannot create a hazard
    assign hazard = idex_mem_read && (idex_rd != '0) &&
                    ((ifid_use_rs1 && ifid_rs1 == idex_rd) ||
                     (ifid_use_rs2 && ifid_rs2 == idex_rd));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: memory freeze FSM, branch flush and load-use stall control
module pipeline_ctrl
    import rv32i_types::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                imem_req,
    input  logic                imem_resp,
    input  logic                dmem_req,
    input  logic                dmem_resp,
    input  logic                idex_mem_read,
    input  logic [REG_W-1:0]    idex_rd,
    input  logic [REG_W-1:0]    ifid_rs1,
    input  logic [REG_W-1:0]    ifid_rs2,
    input  logic                ifid_use_rs1,
    input  logic                ifid_use_rs2,
    input  logic                br_taken_ex,
    output logic                load_pc,
    output logic                load_if_id,
    output logic                load_id_ex,
    output logic                load_ex_mem,
    output logic                load_mem_wb,
    output logic                flush_if_id,
    output logic                flush_id_ex,
    output logic                imem_capture,
    output logic [FREEZE_W-1:0] freeze_cnt,
    output logic [BUBBLE_W-1:0] bubble_cnt
);
    pipe_ctrl_state_t state, state_nx;
    logic i_done, d_done, i_done_nx, d_done_nx;
    logic hazard, freeze, stall, run;

    hazard_detect u_hazard (
        .idex_mem_read(idex_mem_read),
        .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1),
        .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1),
        .ifid_use_rs2(ifid_use_rs2),
        .hazard(hazard)
    );

    // Next state, sticky response flags and gated control outputs; rst low masks everything
    always_comb begin
        freeze       = !((!imem_req || imem_resp || (i_done && state == MEM_WAIT)) &&
                         (!dmem_req || dmem_resp || (d_done && state == MEM_WAIT)));
        run          = rst && !freeze;
        stall        = hazard && !br_taken_ex;
        state_nx     = freeze ? MEM_WAIT : RUN;
        i_done_nx    = freeze && (i_done || imem_resp);
        d_done_nx    = freeze && (d_done || dmem_resp);
        load_pc      = run && !stall;
        load_if_id   = run && !stall;
        load_id_ex   = run;
        load_ex_mem  = run;
        load_mem_wb  = run;
        flush_if_id  = run && br_taken_ex;
        flush_id_ex  = run && (br_taken_ex || hazard);
        imem_capture = rst && freeze && imem_resp;
    end

    // State, flags and saturating event counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            freeze_cnt <= '0;
            bubble_cnt <= '0;
        end else begin
            state      <= state_nx;
            i_done     <= i_done_nx;
            d_done     <= d_done_nx;
            freeze_cnt <= freeze_cnt + FREEZE_W'(freeze && !(&freeze_cnt));
            bubble_cnt <= bubble_cnt + BUBBLE_W'(!freeze && stall && !(&bubble_cnt));
        end
    end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: randomized and directed checks against a behavioural controller model
module tb_pipeline_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req = 0, imem_resp = 0, dmem_req = 0, dmem_resp = 0;
    logic        idex_mem_read = 0, ifid_use_rs1 = 0, ifid_use_rs2 = 0, br_taken_ex = 0;
    logic [4:0]  idex_rd = 0, ifid_rs1 = 0, ifid_rs2 = 0;
    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, flush_id_ex, imem_capture;
    logic [31:0] freeze_cnt;
    logic [15:0] bubble_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: responses already seen during the current freeze, and event totals
    bit          m_i, m_d;
    logic [31:0] m_fc;
    logic [15:0] m_bc;

    pipeline_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
        .br_taken_ex(br_taken_ex),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .imem_capture(imem_capture),
        .freeze_cnt(freeze_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hazard();
        return idex_mem_read && idex_rd != 0 &&
               ((ifid_use_rs1 && ifid_rs1 == idex_rd) || (ifid_use_rs2 && ifid_rs2 == idex_rd));
    endfunction

    function automatic bit m_freeze();
        return !((!imem_req || imem_resp || m_i) && (!dmem_req || dmem_resp || m_d));
    endfunction

    // model outputs packed as {pc, if_id, id_ex, ex_mem, mem_wb, flush_if_id, flush_id_ex, capture}
    function automatic logic [7:0] m_ctrl();
        if (!rst)          return 8'b0000_0000;
        if (m_freeze())    return {7'b0, imem_resp};
        if (br_taken_ex)   return 8'b1111_1110;
        if (m_hazard())    return 8'b0011_1010;
        return 8'b1111_1000;
    endfunction

    // compare every output against the model while inputs are stable
    task automatic settle();
        #1;
        chk("ctrl", {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                     flush_if_id, flush_id_ex, imem_capture}, m_ctrl());
        chk("freeze_cnt", freeze_cnt, m_fc);
        chk("bubble_cnt", {16'b0, bubble_cnt}, {16'b0, m_bc});
    endtask

    // advance one clock and apply the edge rules to the model
    task automatic tick();
        bit fr, hz;
        fr = m_freeze();
        hz = m_hazard();
        @(posedge clk);
        if (rst) begin
            if (fr) begin
                m_i = m_i | imem_resp;
                m_d = m_d | dmem_resp;
                if (m_fc != 32'hFFFF_FFFF) m_fc++;
            end else begin
                m_i = 0;
                m_d = 0;
                if (!br_taken_ex && hz && m_bc != 16'hFFFF) m_bc++;
            end
        end
        @(negedge clk);
    endtask

    task automatic m_reset();
        m_i = 0; m_d = 0; m_fc = 0; m_bc = 0;
    endtask

    task automatic mem(input logic ir, input logic iresp, input logic dr, input logic dresp);
        imem_req = ir; imem_resp = iresp; dmem_req = dr; dmem_resp = dresp;
    endtask

    task automatic hz_in(input logic mr, input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2, input logic br);
        idex_mem_read = mr; idex_rd = rd; ifid_rs1 = r1; ifid_use_rs1 = u1;
        ifid_rs2 = r2; ifid_use_rs2 = u2; br_taken_ex = br;
    endtask

    task automatic do_reset();
        rst = 0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1;
    endtask

    initial begin
        m_reset();
        mem(0, 0, 0, 0);
        hz_in(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        settle();
        chk("reset_load_pc", {31'b0, load_pc}, 0);
        chk("reset_freeze_cnt", freeze_cnt, 0);
        rst = 1;

        // imem response three cycles late
        for (int c = 0; c < 3; c++) begin
            mem(1, 0, 0, 0);
            settle();
            chk("late_imem_load_pc", {31'b0, load_pc}, 0);
            tick();
        end
        mem(1, 1, 0, 0);
        settle();
        chk("late_imem_resp_loads", {27'b0, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}, 32'h1F);
        chk("late_imem_freeze_cnt", freeze_cnt, 3);
        tick();

        // imem and dmem both pending, imem first then dmem
        do_reset();
        mem(1, 0, 1, 0); settle(); tick();
        mem(1, 1, 1, 0); settle();
        chk("split_capture_c1", {31'b0, imem_capture}, 1);
        tick();
        for (int c = 2; c < 4; c++) begin
            mem(1, 0, 1, 0); settle();
            chk("split_capture_low", {31'b0, imem_capture}, 0);
            chk("split_frozen", {31'b0, load_pc}, 0);
            tick();
        end
        mem(1, 0, 1, 1); settle();
        chk("split_release", {31'b0, load_pc}, 1);
        tick();
        mem(1, 0, 0, 0); settle();
        chk("split_i_done_cleared", {31'b0, load_pc}, 0);
        tick();

        // load-use hazard, then the same load into x0
        do_reset();
        mem(0, 0, 0, 0);
        hz_in(1, 5, 0, 0, 5, 1, 0); settle();
        chk("hazard_pc_ifid", {30'b0, load_pc, load_if_id}, 0);
        chk("hazard_flush_id_ex", {31'b0, flush_id_ex}, 1);
        tick();
        chk("hazard_bubble_cnt", {16'b0, bubble_cnt}, 1);
        hz_in(1, 0, 0, 0, 0, 1, 0); settle();
        chk("x0_no_stall", {31'b0, load_pc}, 1);
        tick();
        chk("x0_bubble_cnt", {16'b0, bubble_cnt}, 1);

        // hazard coinciding with a taken branch
        hz_in(1, 7, 7, 1, 0, 0, 1); settle();
        chk("br_hz_flushes", {30'b0, flush_if_id, flush_id_ex}, 3);
        chk("br_hz_load_pc", {31'b0, load_pc}, 1);
        tick();
        chk("br_hz_bubble_cnt", {16'b0, bubble_cnt}, 1);

        // asynchronous reset in the middle of a freeze
        hz_in(0, 0, 0, 0, 0, 0, 0);
        mem(0, 0, 1, 0); settle(); tick(); settle(); tick();
        #3 rst = 0;
        #1;
        chk("async_rst_ctrl", {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                               flush_if_id, flush_id_ex, imem_capture}, 0);
        chk("async_rst_freeze_cnt", freeze_cnt, 0);
        m_reset();
        @(negedge clk);
        rst = 1;
        mem(0, 0, 1, 1); settle();
        chk("after_rst_run", {31'b0, load_pc}, 1);
        tick();

        // counter saturation
        force dut.freeze_cnt = 32'hFFFF_FFFF;
        m_fc = 32'hFFFF_FFFF;
        mem(1, 0, 0, 0); settle();
        release dut.freeze_cnt;
        tick();
        settle();
        chk("freeze_cnt_saturated", freeze_cnt, 32'hFFFF_FFFF);
        tick();

        // randomized traffic with occasional asynchronous resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            mem($urandom_range(0, 1), $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
            hz_in($urandom_range(0, 1), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 1),
                  5'($urandom_range(0, 3)), $urandom_range(0, 1),
                  $urandom_range(0, 5) == 0);
            settle();
            if ($urandom_range(0, 199) == 0) begin
                #2 rst = 0;
                m_reset();
                #1;
                chk("rand_rst_ctrl", {24'b0, load_pc, load_if_id, load_id_ex, load_ex_mem,
                                      load_mem_wb, flush_if_id, flush_id_ex, imem_capture}, 0);
                @(negedge clk);
                rst = 1;
            end else begin
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  asynchronous, active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-003 imem_req / imem_resp  in  1/1  IF fetch outstanding / instruction memory response valid this cycle.
REQ-004 dmem_req / dmem_resp  in  1/1  MEM-stage load or store outstanding / data memory response valid this cycle.
REQ-005 idex_mem_read  in  1  instruction in ID/EX is a load.
REQ-006 idex_rd  in  5  destination register of the ID/EX instruction.
REQ-007 ifid_rs1, ifid_rs2  in  5 each  source registers of the IF/ID instruction.
REQ-008 ifid_use_rs1, ifid_use_rs2  in  1 each  the IF/ID instruction reads that source.
REQ-009 br_taken_ex  in  1  EX-stage branch or jump redirects PC this cycle.
REQ-010 load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  load enables for the PC and the four stage registers.
REQ-011 flush_if_id, flush_id_ex  out  1 each  load a zero bubble into that stage register on this edge.
REQ-012 imem_capture  out  1  pulse: latch the fetched instruction into the IF hold buffer.
REQ-013 freeze_cnt  out  32  saturating count of memory-freeze cycles.
REQ-014 bubble_cnt  out  16  saturating count of load-use bubbles inserted.

Function
REQ-015 States: RUN, MEM_WAIT; sticky flags i_done, d_done.
- i_sat = !imem_req | imem_resp | i_done; d_sat = !dmem_req | dmem_resp | d_done; freeze = !(i_sat & d_sat).
REQ-016 freeze=1: all load_* = 0; flush_* = 0; next state MEM_WAIT.
REQ-017 freeze=0: next state RUN; i_done and d_done clear on that edge.
REQ-018 imem_resp while freeze=1 sets i_done and asserts imem_capture that cycle. dmem_resp while freeze=1 sets d_done.
REQ-019 Zero-wait case: req and resp in the same cycle with no other stall gives no freeze and no state change.
REQ-020 Branch (freeze=0, br_taken_ex=1):
- all load_* = 1;
- flush_if_id = 1, flush_id_ex = 1.
REQ-021 Load-use hazard: idex_mem_read & idex_rd!=0 & ((ifid_use_rs1 & ifid_rs1==idex_rd) | (ifid_use_rs2 & ifid_rs2==idex_rd)).
REQ-022 Hazard with freeze=0 and br_taken_ex=0:
- load_pc = 0, load_if_id = 0;
- flush_id_ex = 1;
- load_ex_mem = 1, load_mem_wb = 1.
REQ-023 No freeze, no branch, no hazard: all load_* = 1, flushes 0.
REQ-024 Priority: freeze > branch > hazard. A branch squashes the hazarding IF/ID instruction, so no bubble is counted.
REQ-025 Outputs are combinational from state, flags and inputs; flush_* is never asserted while the matching load_* = 0.
REQ-026 freeze_cnt +1 on each freeze=1 edge. bubble_cnt +1 on each REQ-022 edge. Both counters hold at all-ones.

Reset
REQ-027 While rst=0:
- state = RUN; i_done = d_done = 0;
- both counters 0;
- all load_*, flush_* and imem_capture forced 0.
REQ-028 Reset asserted during MEM_WAIT discards flags; first cycle after release evaluates as RUN.

Structure
REQ-029 pipe_ctrl_state_t (RUN, MEM_WAIT) lives in rv32i_types.
REQ-030 The load-use comparison is a combinational sub-module hazard_detect; pipeline_ctrl holds the FSM, flags and counters.

Verification
REQ-031 imem_req=1, imem_resp 3 cycles late -> loads 0 for 3 cycles, freeze_cnt=3, all loads 1 on the resp cycle.
REQ-032 imem and dmem both pending; imem_resp at cycle 1, dmem_resp at cycle 4 -> imem_capture pulses at cycle 1, freeze through cycle 3, release at cycle 4, i_done cleared.
REQ-033 idex_mem_read=1, idex_rd=5, ifid_rs2=5, use_rs2=1 -> load_pc=load_if_id=0, flush_id_ex=1, bubble_cnt=1; idex_rd=0 case gives no bubble.
REQ-034 Hazard and br_taken_ex same cycle -> both flushes 1, all loads 1, bubble_cnt unchanged.
REQ-035 rst pulsed low mid-MEM_WAIT, asynchronous to clk -> outputs 0 immediately, counters 0, RUN after release.
REQ-036 Force freeze_cnt to 0xFFFFFFFF, then one more freeze cycle -> freeze_cnt stays 0xFFFFFFFF.
